ccff_chain_loader: RTL and testbench

Configuration-chain loader for the programmable fabric tiles, including the CLB `fle` tile. It takes bitstream words from the host-side configuration interface and serializes them MSB-first onto a tile's `ccff_head`. It raises a clock-gate enable for every cycle a bit must shift, so the chain advances only when valid data is present. An optional verify pass compares the bits leaving `ccff_tail` against the bits being loaded and counts mismatches, all without bitstream storage.

---
 rtl/ccff_chain_loader_if.sv | 12 +
 rtl/ccff_chain_loader.sv | 146 ++++++++++++++
 tb/tb_ccff_chain_loader.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ccff_chain_loader_if.sv
// Host-side configuration word channel for ccff_chain_loader.
// The host drives valid/data; the loader answers with ready.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 32
) ();
  logic              wr_valid;
  logic [WORD_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes host configuration words MSB-first onto a tile's ccff chain,
// gating the chain clock per shifted bit and optionally counting verify mismatches.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 40,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  input  logic                 start,
  input  logic                 verify,
  ccff_chain_loader_if.slave   host,
  output logic                 ccff_head,
  input  logic                 ccff_tail,
  output logic                 ccff_clk_en,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     bit_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_W  = CHAIN_LEN - (N_WORDS - 1) * WORD_W;
  localparam int BL_W    = $clog2(WORD_W + 1);
  localparam int WA_W    = $clog2(N_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] buffer;
  logic [BL_W-1:0]   bits_left;
  logic [WA_W-1:0]   words_acc;
  logic              verify_q;

  state_t            nxt_state;
  logic [WORD_W-1:0] nxt_buffer;
  logic [BL_W-1:0]   nxt_bits_left;
  logic [WA_W-1:0]   nxt_words_acc;
  logic              nxt_verify_q;
  logic [CNT_W-1:0]  nxt_bit_cnt;
  logic [CNT_W-1:0]  nxt_err_cnt;
  logic              nxt_ready;
  logic              nxt_clk_en;
  logic              shift;
  logic              accept;

  // Next-state decode; outputs are derived from next state so they leave flops directly
  always_comb begin
    nxt_state     = state;
    nxt_buffer    = buffer;
    nxt_bits_left = bits_left;
    nxt_words_acc = words_acc;
    nxt_verify_q  = verify_q;
    nxt_bit_cnt   = bit_cnt;
    nxt_err_cnt   = err_cnt;
    shift         = (state == LOAD) && (bits_left != {BL_W{1'b0}});
    accept        = host.wr_valid && host.wr_ready;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          nxt_state     = LOAD;
          nxt_buffer    = {WORD_W{1'b0}};
          nxt_bits_left = {BL_W{1'b0}};
          nxt_words_acc = {WA_W{1'b0}};
          nxt_verify_q  = verify;
          nxt_bit_cnt   = {CNT_W{1'b0}};
          nxt_err_cnt   = {CNT_W{1'b0}};
        end else begin
          nxt_state = state;
        end
      end
      LOAD: begin
        if (shift) begin
          nxt_buffer    = {buffer[WORD_W-2:0], 1'b0};
          nxt_bits_left = bits_left - BL_W'(1);
          nxt_bit_cnt   = bit_cnt + CNT_W'(1);
          if (verify_q && (ccff_tail != buffer[WORD_W-1]) &&
              (err_cnt != CNT_W'(CHAIN_LEN))) begin
            nxt_err_cnt = err_cnt + CNT_W'(1);
          end else begin
            nxt_err_cnt = err_cnt;
          end
          if (bit_cnt == CNT_W'(CHAIN_LEN - 1)) begin
            nxt_state = DONE;
          end else begin
            nxt_state = LOAD;
          end
        end else begin
          nxt_state = LOAD;
        end
        // A refill on the last-bit edge replaces the shifted word: zero-bubble handover
        if (accept) begin
          nxt_buffer    = host.wr_data;
          nxt_bits_left = (words_acc == WA_W'(N_WORDS - 1)) ? BL_W'(LAST_W) : BL_W'(WORD_W);
          nxt_words_acc = words_acc + WA_W'(1);
        end else begin
          nxt_words_acc = words_acc;
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase

    nxt_clk_en = (nxt_state == LOAD) && (nxt_bits_left != {BL_W{1'b0}});
    nxt_ready  = (nxt_state == LOAD) && (nxt_bits_left <= BL_W'(1)) &&
                 (nxt_words_acc < WA_W'(N_WORDS));
  end

  // State, datapath and registered outputs with synchronous reset
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state         <= IDLE;
      buffer        <= {WORD_W{1'b0}};
      bits_left     <= {BL_W{1'b0}};
      words_acc     <= {WA_W{1'b0}};
      verify_q      <= 1'b0;
      bit_cnt       <= {CNT_W{1'b0}};
      err_cnt       <= {CNT_W{1'b0}};
      host.wr_ready <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_clk_en   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= nxt_state;
      buffer        <= nxt_buffer;
      bits_left     <= nxt_bits_left;
      words_acc     <= nxt_words_acc;
      verify_q      <= nxt_verify_q;
      bit_cnt       <= nxt_bit_cnt;
      err_cnt       <= nxt_err_cnt;
      host.wr_ready <= nxt_ready;
      ccff_head     <= nxt_buffer[WORD_W-1];
      ccff_clk_en   <= nxt_clk_en;
      busy          <= (nxt_state == LOAD);
      done          <= (nxt_state == DONE);
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a 40-flop chain model on the gated clock.
module tb_ccff_chain_loader;
  localparam int CHAIN_LEN = 40;
  localparam int WORD_W    = 32;
  localparam int CNT_W     = 6;

  logic             prog_clk = 1'b0;
  logic             pReset;
  logic             start;
  logic             verify;
  logic             ccff_head;
  logic             ccff_tail;
  logic             ccff_clk_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] err_cnt;

  ccff_chain_loader_if #(.WORD_W(WORD_W)) host ();

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .start       (start),
    .verify      (verify),
    .host        (host),
    .ccff_head   (ccff_head),
    .ccff_tail   (ccff_tail),
    .ccff_clk_en (ccff_clk_en),
    .busy        (busy),
    .done        (done),
    .bit_cnt     (bit_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 prog_clk = ~prog_clk;

  logic [CHAIN_LEN-1:0] chain = '0;
  always @(posedge prog_clk) if (ccff_clk_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  assign ccff_tail = chain[CHAIN_LEN-1];

  int n_tests = 0;
  int n_fail  = 0;

  int                   en_cnt, stall_cnt, cyc;
  logic [CHAIN_LEN-1:0] cap;
  logic                 ready_late;
  logic [CNT_W-1:0]     mid_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one load from start to done; gap = cycles the host withholds word 2 after ready rises
  task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input int gap,
                          input logic vfy, input int start_at);
    int   words_sent = 0;
    int   gap_left   = 0;
    logic acc        = 1'b0;
    logic pulsed     = 1'b0;
    en_cnt = 0; stall_cnt = 0; cap = '0; ready_late = 1'b0; mid_err = '0;
    @(negedge prog_clk); start = 1'b1; verify = vfy;
    @(negedge prog_clk); start = 1'b0; verify = 1'b0;
    cyc = 1;
    for (int i = 0; i < 300; i++) begin
      if (i > 0) begin @(negedge prog_clk); cyc++; end
      start = 1'b0;
      if (done) break;
      if (ccff_clk_en) begin cap = {cap[CHAIN_LEN-2:0], ccff_head}; en_cnt++; end
      else if (en_cnt > 0) stall_cnt++;
      if (acc) begin words_sent++; host.wr_valid = 1'b0; gap_left = gap; end
      if (words_sent == 2 && host.wr_ready) ready_late = 1'b1;
      if (!pulsed && start_at >= 0 && bit_cnt == CNT_W'(start_at)) begin
        start = 1'b1; pulsed = 1'b1; mid_err = err_cnt;
      end
      if (!host.wr_valid && host.wr_ready && words_sent < 2) begin
        if (words_sent == 1 && gap_left > 0) gap_left--;
        else begin host.wr_valid = 1'b1; host.wr_data = (words_sent == 0) ? w0 : w1; end
      end
      acc = host.wr_valid && host.wr_ready;
    end
    host.wr_valid = 1'b0;
    check_eq("load_reached_done", 64'(done), 64'd1);
  endtask

  localparam logic [31:0] A0 = 32'hDEADBEEF;
  localparam logic [31:0] A1 = 32'hA5FFFFFF;
  localparam logic [31:0] B0 = 32'h5EADBEEE;
  localparam logic [31:0] B1 = 32'hA4FFFFFF;

  initial begin
    pReset = 1'b1; start = 1'b0; verify = 1'b0;
    host.wr_valid = 1'b0; host.wr_data = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge prog_clk);
      start = 1'($urandom_range(0, 1)); verify = 1'($urandom_range(0, 1));
      host.wr_valid = 1'($urandom_range(0, 1)); host.wr_data = $urandom;
    end
    @(negedge prog_clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_ready", 64'(host.wr_ready), 64'd0);
    check_eq("rst_head", 64'(ccff_head), 64'd0);
    check_eq("rst_clk_en", 64'(ccff_clk_en), 64'd0);
    check_eq("rst_bit_cnt", 64'(bit_cnt), 64'd0);
    check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
    start = 1'b1; host.wr_valid = 1'b0;
    @(negedge prog_clk);
    check_eq("start_in_rst_busy", 64'(busy), 64'd0);
    pReset = 1'b0; start = 1'b0; verify = 1'b0;
    @(negedge prog_clk);
    check_eq("idle_after_rst", 64'(busy), 64'd0);

    // Back-to-back words
    run_load(A0, A1, 0, 1'b0, -1);
    check_eq("b2b_en_cycles", 64'(en_cnt), 64'd40);
    check_eq("b2b_stalls", 64'(stall_cnt), 64'd0);
    check_eq("b2b_head_seq", 64'(cap), {24'h0, A0, 8'hA5});
    check_eq("b2b_ready_late", 64'(ready_late), 64'd0);
    check_eq("b2b_bit_cnt", 64'(bit_cnt), 64'd40);
    check_eq("b2b_load_time", 64'(cyc), 64'd42);
    check_eq("b2b_clk_en_off", 64'(ccff_clk_en), 64'd0);
    check_eq("b2b_ready_off", 64'(host.wr_ready), 64'd0);
    @(negedge prog_clk);
    check_eq("done_held", 64'(done), 64'd1);

    // Host stalls 5 cycles before the second word
    run_load(A0, A1, 5, 1'b0, -1);
    check_eq("stall_en_cycles", 64'(en_cnt), 64'd40);
    check_eq("stall_gap", 64'(stall_cnt), 64'd5);
    check_eq("stall_head_seq", 64'(cap), {24'h0, A0, 8'hA5});
    check_eq("stall_load_time", 64'(cyc), 64'd47);

    // Verify passes: B differs from A in load bits 0, 31 and 39
    run_load(A0, A1, 0, 1'b0, -1);
    run_load(A0, A1, 0, 1'b1, -1);
    check_eq("verify_same_err", 64'(err_cnt), 64'd0);
    run_load(B0, B1, 2, 1'b1, -1);
    check_eq("verify_diff_err", 64'(err_cnt), 64'd3);
    check_eq("verify_diff_bits", 64'(bit_cnt), 64'd40);

    // start pulsed mid-load is ignored; chain currently holds B
    run_load(A0, A1, 0, 1'b1, 20);
    check_eq("mid_start_err_at20", 64'(mid_err), 64'd1);
    check_eq("mid_start_bit_cnt", 64'(bit_cnt), 64'd40);
    check_eq("mid_start_err", 64'(err_cnt), 64'd3);
    check_eq("mid_start_time", 64'(cyc), 64'd42);

    // Reset after 10 shifted bits
    @(negedge prog_clk); start = 1'b1;
    @(negedge prog_clk); start = 1'b0; host.wr_valid = 1'b1; host.wr_data = A0;
    for (int i = 0; i < 100; i++) begin
      @(negedge prog_clk); host.wr_valid = 1'b0;
      if (bit_cnt == CNT_W'(10)) break;
    end
    check_eq("pre_rst_bit_cnt", 64'(bit_cnt), 64'd10);
    pReset = 1'b1;
    @(negedge prog_clk);
    pReset = 1'b0;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_clk_en", 64'(ccff_clk_en), 64'd0);
    check_eq("midrst_bit_cnt", 64'(bit_cnt), 64'd0);
    check_eq("midrst_ready", 64'(host.wr_ready), 64'd0);
    run_load(B0, B1, 0, 1'b0, -1);
    check_eq("post_rst_bit_cnt", 64'(bit_cnt), 64'd40);
    check_eq("post_rst_head_seq", 64'(cap), {24'h0, B0, 8'hA4});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
